lsu_dmem_port: RTL and testbench
================================

# lsu_dmem_port

Load/store front end that converts single load/store micro-ops from the CPU memory stage into requests on the 32-bit masked data-memory port. It builds the word address and byte masks, lane-shifts store data, and tracks one outstanding access. It sign- or zero-extends the returned load data and reports a completion to writeback. It sits directly upstream of the pipelined masked data memory, which stalls a variable number of cycles per access.

## Interface
- No parameters.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (reset when rst==0 at a rising edge)
- req_valid  in  1  micro-op present
- req_ready  out  1  micro-op accepted this cycle when req_valid&&req_ready
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  load destination tag, echoed on response
- rsp_valid  out  1  access complete this cycle (single-cycle pulse, no backpressure)
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_rd  out  5  echoed tag
- rsp_err  out  1  misaligned access (see Configuration)
- dmem_addr  out  32  word-aligned address, bits[1:0]=00
- dmem_rmask  out  4  byte read mask
- dmem_wmask  out  4  byte write mask
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data, valid when dmem_resp
- dmem_resp  in  1  access complete

## Operation
- FSM states: IDLE, WAIT. Memory samples a new request on any edge where it is not stalled: the issue edge from IDLE, or the edge of a dmem_resp cycle.
- req_ready = (state==IDLE) || (state==WAIT && dmem_resp).
- When req_valid&&req_ready, drive dmem_* combinationally from req_*; otherwise dmem_rmask=dmem_wmask=0, dmem_addr=0, dmem_wdata=0. Never assert rmask and wmask together.
- Masks, with off=req_addr[1:0]: B → 4'b0001<<off; H → 4'b0011<<off; W → 4'b1111. Loads use rmask, stores use wmask.
- dmem_wdata = req_wdata << (8*off), computed in 32 bits with overflow discarded.
- On acceptance, register funct3, off, we and rd into the pending op, and go to WAIT.
- In WAIT with dmem_resp: rsp_valid=1. Load data = dmem_rdata >> (8*off), truncated to 8 or 16 bits and sign-extended (B/H) or zero-extended (BU/HU). W loads pass through unchanged.
- In WAIT with dmem_resp and no new acceptance, go to IDLE. With a new acceptance (back-to-back), stay in WAIT with the new pending op.
- dmem_resp outside WAIT is ignored.
- funct3 values 011, 110, 111 are treated as W.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_rd=0, all dmem_* outputs=0.
- Minimum latency: accept at cycle N → rsp_valid in cycle N+1 (memory hit). Each extra memory stall cycle adds one cycle.
- Throughput: one access per cycle while the memory returns dmem_resp every cycle.
- Reset mid-WAIT: pending op discarded, no rsp_valid, state=IDLE on the next cycle.
- rsp_* outputs are combinational from the pending op and dmem_rdata; they are meaningful only while rsp_valid=1, and read as 0 otherwise.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - H/HU with addr[0]=1, or W with addr[1:0]≠0, is accepted but issues no memory request.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0, state returns to IDLE.
- LSU_MISALIGN_CHECK_EN undefined:
  - No check is made; rsp_err is tied to 0.
  - The address is forced to natural alignment: H clears addr[0], W clears addr[1:0] before mask/shift generation.

## Structure
- lsu_pkg holds:
  - the funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - the state enum lsu_state_t
  - the pending-op struct lsu_pend_t {we, funct3, off, rd, err}
- One sub-module, lsu_load_align: combinational shift and extend of dmem_rdata by off/funct3.

## Test plan
- LW 0x100, memory word 0xDEADBEEF, zero stall → dmem_rmask=1111, dmem_addr=0x100, rsp_rdata=0xDEADBEEF one cycle after accept.
- LB 0x103 with word 0x80FF_0000 → rmask=1000, rsp_rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH 0x102 data 0x0000_1234 → wmask=1100, dmem_wdata=0x1234_0000. Subsequent LW 0x100 returns 0x1234xxxx, with the low half unchanged.
- Back-to-back LW 0x0, 0x4, 0x8 with 5-cycle stall on the first → req_ready=0 during the stall and 1 in each resp cycle, three rsp_valid pulses in order with correct rd tags.
- Reset asserted (rst=0) in WAIT → no rsp_valid, all outputs 0. After release, LW completes normally.
- With LSU_MISALIGN_CHECK_EN, LW 0x102 → no dmem mask asserted, rsp_err=1 next cycle. Without it → dmem_addr=0x100, rmask=1111, rsp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the LSU data-memory front end.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT
    } lsu_state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
        logic [4:0] rd;
        logic       err;
    } lsu_pend_t;

    // The unused encodings (011, 110, 111) fall through to word width.
    function automatic logic is_byte(input logic [2:0] funct3);
        return (funct3 == LSU_B) || (funct3 == LSU_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] funct3);
        return (funct3 == LSU_H) || (funct3 == LSU_HU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/half of a returned memory word down to bit 0
// and sign- or zero-extends it according to the load's funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic        sign;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        sign    = 1'b0;
        data    = shifted;
        if (is_byte(funct3)) begin
            sign = (funct3 == LSU_B) & shifted[7];
            data = {{24{sign}}, shifted[7:0]};
        end else if (is_half(funct3)) begin
            sign = (funct3 == LSU_H) & shifted[15];
            data = {{16{sign}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/lsu_dmem_port.sv
// Load/store front end onto the masked 32-bit data memory; one access in flight.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses instead of aligning them.
module lsu_dmem_port
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    lsu_state_t  state;
    lsu_pend_t   pend;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic        misalign;
    logic        done;
    logic        accept;
    logic [31:0] load_data;

    always_comb begin
        off      = req_addr[1:0];
        misalign = 1'b0;
        if (is_half(req_funct3)) begin
`ifdef LSU_MISALIGN_CHECK_EN
            misalign = req_addr[0];
`else
            off[0] = 1'b0;
`endif
        end else if (!is_byte(req_funct3)) begin
`ifdef LSU_MISALIGN_CHECK_EN
            misalign = |req_addr[1:0];
`else
            off = 2'b00;
`endif
        end
    end

    // A trapped access never reaches memory, so it completes without dmem_resp.
    assign done      = (state == WAIT) && (pend.err || dmem_resp);
    assign req_ready = (state == IDLE) || done;
    assign accept    = rst && req_valid && req_ready;

    always_comb begin
        dmem_addr  = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        mask       = 4'b1111;
        if (is_byte(req_funct3)) begin
            mask = 4'b0001 << off;
        end else if (is_half(req_funct3)) begin
            mask = 4'b0011 << off;
        end
        if (accept && !misalign) begin
            dmem_addr  = {req_addr[31:2], 2'b00};
            dmem_wdata = req_wdata << {off, 3'b000};
            if (req_we) begin
                dmem_wmask = mask;
            end else begin
                dmem_rmask = mask;
            end
        end
    end

    lsu_load_align u_align (
        .rdata  (dmem_rdata),
        .off    (pend.off),
        .funct3 (pend.funct3),
        .data   (load_data)
    );

    assign rsp_valid = rst && done;
    assign rsp_rd    = rsp_valid ? pend.rd : 5'd0;
    assign rsp_err   = rsp_valid ? pend.err : 1'b0;
    assign rsp_rdata = (rsp_valid && !pend.we && !pend.err) ? load_data : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pend  <= '0;
        end else if (accept) begin
            state <= WAIT;
            pend  <= '{we: req_we, funct3: req_funct3, off: off, rd: req_rd, err: misalign};
        end else if (done) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Self-checking bench for lsu_dmem_port: the bench plays the data memory and
// predicts every output from a byte-level model of loads and stores.
module tb_lsu_dmem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp;

    always #5 clk = ~clk;

    lsu_dmem_port dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          stall;
        logic        pin_en;
        logic [3:0]  pin_mask;
        logic [31:0] pin_addr;
        logic [31:0] pin_data;
        logic        pin_err;
    } op_t;

    logic [31:0] mem [0:255];
    op_t         queue[$];
    logic        m_busy = 1'b0;
    op_t         m_op;
    logic        m_err;
    int          m_stall;
    logic [31:0] m_word;
    logic        spur = 1'b0;
    int          checks = 0;
    int          passed = 0;
    int          rsp_seen = 0;

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic is_signed(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001);
    endfunction

    function automatic logic model_misaligned(input op_t o);
`ifdef LSU_MISALIGN_CHECK_EN
        return (o.addr % size_of(o.f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] eff_addr(input op_t o);
        return o.addr - (o.addr % size_of(o.f3));
    endfunction

    function automatic logic [3:0] model_mask(input op_t o);
        logic [4:0]  full;
        logic [31:0] e;
        e    = eff_addr(o);
        full = (5'd1 << size_of(o.f3)) - 5'd1;
        return full[3:0] << e[1:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input op_t o);
        logic [63:0] v;
        logic [31:0] e;
        int          sz;
        e  = eff_addr(o);
        sz = size_of(o.f3);
        v  = ({32'd0, word} >> (8 * e[1:0])) & ((64'd1 << (8 * sz)) - 64'd1);
        if (is_signed(o.f3) && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic op_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd, input int stall);
        op_t o;
        o.we = we; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rd = rd; o.stall = stall;
        o.pin_en = 1'b0; o.pin_mask = '0; o.pin_addr = '0; o.pin_data = '0; o.pin_err = 1'b0;
        return o;
    endfunction

    function automatic op_t pin(input op_t o, input logic [3:0] m, input logic [31:0] a,
                                input logic [31:0] d, input logic e);
        op_t p;
        p = o;
        p.pin_en = 1'b1; p.pin_mask = m; p.pin_addr = a; p.pin_data = d; p.pin_err = e;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input logic rst_v);
        op_t         h;
        logic        have, resp, done, accept, merr;
        logic [3:0]  emask;
        logic [31:0] e, wsh;
        @(negedge clk);
        have = rst_v && (queue.size() > 0);
        rst  = rst_v;
        req_valid = have;
        if (have) begin
            h = queue[0];
            req_we = h.we; req_funct3 = h.f3; req_addr = h.addr; req_wdata = h.wdata; req_rd = h.rd;
        end else begin
            req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; req_rd = '0;
        end
        resp       = m_busy && !m_err && (m_stall == 0);
        dmem_resp  = resp || (!m_busy && spur);
        dmem_rdata = resp ? m_word : $urandom();
        #1;
        done   = rst_v && m_busy && (m_err || resp);
        accept = have && (!m_busy || m_err || resp);
        merr   = accept && model_misaligned(h);
        emask  = (accept && !merr) ? model_mask(h) : 4'b0000;
        e      = accept ? eff_addr(h) : 32'd0;
        wsh    = accept ? (h.wdata << (8 * e[1:0])) : 32'd0;
        if (rsp_valid) rsp_seen++;

        if (rst_v) checkOutput("req_ready", {31'd0, req_ready}, {31'd0, (!m_busy || m_err || resp)});
        checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, done});
        checkOutput("rsp_rd", {27'd0, rsp_rd}, done ? {27'd0, m_op.rd} : 32'd0);
        checkOutput("rsp_err", {31'd0, rsp_err}, done ? {31'd0, m_err} : 32'd0);
        checkOutput("rsp_rdata", rsp_rdata, (done && !m_op.we && !m_err) ? model_load(m_word, m_op) : 32'd0);
        checkOutput("dmem_rmask", {28'd0, dmem_rmask}, (accept && !h.we) ? {28'd0, emask} : 32'd0);
        checkOutput("dmem_wmask", {28'd0, dmem_wmask}, (accept && h.we) ? {28'd0, emask} : 32'd0);
        if (emask != 0) checkOutput("dmem_addr", dmem_addr, e & 32'hFFFF_FFFC);
        if (emask != 0 && h.we) checkOutput("dmem_wdata", dmem_wdata, wsh);
        if (accept && h.pin_en) begin
            checkOutput("pin_mask", {28'd0, dmem_rmask | dmem_wmask}, {28'd0, h.pin_mask});
            if (h.pin_mask != 0) checkOutput("pin_addr", dmem_addr, h.pin_addr);
            if (h.we) checkOutput("pin_wdata", dmem_wdata, h.pin_data);
        end
        if (done && m_op.pin_en) begin
            if (!m_op.we) checkOutput("pin_rdata", rsp_rdata, m_op.pin_data);
            checkOutput("pin_err", {31'd0, rsp_err}, {31'd0, m_op.pin_err});
        end

        @(posedge clk);
        if (!rst_v) begin
            m_busy = 1'b0;
        end else begin
            if (done) m_busy = 1'b0;
            else if (m_busy && !m_err) m_stall--;
            if (accept) begin
                void'(queue.pop_front());
                m_busy = 1'b1; m_op = h; m_err = merr; m_stall = h.stall;
                if (!merr) begin
                    if (h.we) begin
                        for (int b = 0; b < 4; b++)
                            if (emask[b]) mem[e[9:2]][8*b +: 8] = wsh[8*b +: 8];
                    end else begin
                        m_word = mem[e[9:2]];
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((queue.size() > 0 || m_busy) && n < 300) begin
            applyStimulus(1'b1);
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("[TB] FAIL drain_timeout: actual still busy after 300 cycles, required idle");
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
        mem[64] = 32'hDEAD_BEEF;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; dmem_resp = 1'b0; dmem_rdata = '0;

        applyStimulus(1'b0);
        applyStimulus(1'b0);
        applyStimulus(1'b1);

        $display("[TB] widths, extension and store lanes");
        queue.push_back(pin(mk(0, 3'b010, 32'h100, 0, 5'd5, 0), 4'b1111, 32'h100, 32'hDEAD_BEEF, 0));
        queue.push_back(pin(mk(1, 3'b010, 32'h100, 32'h80FF_0000, 5'd0, 0), 4'b1111, 32'h100, 32'h80FF_0000, 0));
        queue.push_back(pin(mk(0, 3'b000, 32'h103, 0, 5'd6, 1), 4'b1000, 32'h100, 32'hFFFF_FF80, 0));
        queue.push_back(pin(mk(0, 3'b100, 32'h103, 0, 5'd7, 0), 4'b1000, 32'h100, 32'h0000_0080, 0));
        queue.push_back(pin(mk(1, 3'b001, 32'h102, 32'h0000_1234, 5'd0, 2), 4'b1100, 32'h100, 32'h1234_0000, 0));
        queue.push_back(pin(mk(0, 3'b010, 32'h100, 0, 5'd8, 0), 4'b1111, 32'h100, 32'h1234_0000, 0));
        queue.push_back(pin(mk(0, 3'b001, 32'h102, 0, 5'd9, 0), 4'b1100, 32'h100, 32'h0000_1234, 0));
        queue.push_back(pin(mk(1, 3'b000, 32'h101, 32'h0000_00AB, 5'd0, 0), 4'b0010, 32'h100, 32'h0000_AB00, 0));
        queue.push_back(pin(mk(0, 3'b001, 32'h100, 0, 5'd10, 0), 4'b0011, 32'h100, 32'hFFFF_AB00, 0));
        queue.push_back(pin(mk(0, 3'b101, 32'h100, 0, 5'd11, 3), 4'b0011, 32'h100, 32'h0000_AB00, 0));
        queue.push_back(pin(mk(0, 3'b011, 32'h100, 0, 5'd12, 0), 4'b1111, 32'h100, 32'h1234_AB00, 0));
        queue.push_back(pin(mk(0, 3'b110, 32'h100, 0, 5'd13, 0), 4'b1111, 32'h100, 32'h1234_AB00, 0));
        drain();

        $display("[TB] spurious dmem_resp while idle");
        spur = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        spur = 1'b0;

        $display("[TB] back-to-back loads with a stalled first access");
        rsp_seen = 0;
        queue.push_back(pin(mk(0, 3'b010, 32'h0, 0, 5'd1, 5), 4'b1111, 32'h0, 32'h1111_1111, 0));
        queue.push_back(pin(mk(0, 3'b010, 32'h4, 0, 5'd2, 0), 4'b1111, 32'h4, 32'h2222_2222, 0));
        queue.push_back(pin(mk(0, 3'b010, 32'h8, 0, 5'd3, 0), 4'b1111, 32'h8, 32'h3333_3333, 0));
        drain();
        checkOutput("b2b_rsp_count", rsp_seen, 32'd3);

        $display("[TB] reset while waiting on memory");
        queue.push_back(mk(0, 3'b010, 32'h100, 0, 5'd14, 20));
        n = 0;
        while (!m_busy && n < 10) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput("reset_setup_busy", {31'd0, m_busy}, 32'd1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        rsp_seen = 0;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("reset_no_rsp", rsp_seen, 32'd0);
        queue.push_back(pin(mk(0, 3'b010, 32'h4, 0, 5'd15, 1), 4'b1111, 32'h4, 32'h2222_2222, 0));
        drain();

        $display("[TB] misaligned accesses");
`ifdef LSU_MISALIGN_CHECK_EN
        queue.push_back(pin(mk(0, 3'b010, 32'h102, 0, 5'd16, 0), 4'b0000, 32'h0, 32'h0, 1));
        queue.push_back(pin(mk(0, 3'b001, 32'h103, 0, 5'd17, 0), 4'b0000, 32'h0, 32'h0, 1));
`else
        queue.push_back(pin(mk(0, 3'b010, 32'h102, 0, 5'd16, 0), 4'b1111, 32'h100, 32'h1234_AB00, 0));
        queue.push_back(pin(mk(0, 3'b001, 32'h103, 0, 5'd17, 0), 4'b1100, 32'h100, 32'h0000_1234, 0));
`endif
        queue.push_back(pin(mk(0, 3'b010, 32'h8, 0, 5'd18, 0), 4'b1111, 32'h8, 32'h3333_3333, 0));
        drain();

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
